fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register for the 5-stage RV32I core; sits directly upstream of decode.
- Holds the PC and gates fetching on the top-level start strobe.
- Drives the instruction-memory read address.
- Handles stall, flush and branch/jump redirect from the hazard unit and execute stage.
- Detects a halt instruction and stops fetching, emitting NOP bubbles.

---
 rtl/rv_pkg.sv | 13 +
 rtl/if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 75 +++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants and types for the RV32I pipeline.
package rv_pkg;
  localparam int          XLEN       = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] HALT_INSTR = 32'h0000_0073;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// Pipeline register: instruction, PC, PC+4 and valid bit.
// Flush replaces the contents with a bubble and wins over stall.
module if_id_reg
  import rv_pkg::*;
#(
  parameter int          W   = 32,
  parameter logic [31:0] NOP = rv_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic [31:0]  instr,
  input  logic [W-1:0] pc,
  input  logic [W-1:0] pc4,
  output logic [31:0]  instr_q,
  output logic [W-1:0] pc_q,
  output logic [W-1:0] pc4_q,
  output logic         vld_q
);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr_q <= NOP;
      pc_q    <= '0;
      pc4_q   <= '0;
      vld_q   <= 1'b0;
    end else if (!stall) begin
      instr_q <= instr;
      pc_q    <= pc;
      pc4_q   <= pc4;
      vld_q   <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection, start/halt FSM, and the IF/ID register.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int             XLEN       = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = rv_pkg::RESET_PC,
  parameter logic [31:0]    NOP_INSTR  = rv_pkg::NOP_INSTR,
  parameter logic [31:0]    HALT_INSTR = rv_pkg::HALT_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            halted
);
  fetch_state_e    state;
  logic [XLEN-1:0] pcf, pcf4;
  logic            run, halt_take, ifid_flush;

  assign imem_addr = pcf;
  assign pcf4      = pcf + XLEN'(4);
  assign run       = (state == RUN);

  // A halt word only counts on the committed path with both stages moving;
  // under StallF it is simply refetched and seen again.
  assign halt_take = run && (imem_rdata == HALT_INSTR) &&
                     !PCSrcE && !StallF && !StallD && !FlushD;

  assign ifid_flush = !run || FlushD || PCSrcE;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcf    <= RESET_PC;
      state  <= IDLE;
      halted <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (PCSrcE) pcf <= PCTargetE;
          else if (halt_take) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (!StallF) pcf <= pcf4;
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

  if_id_reg #(.W(XLEN), .NOP(NOP_INSTR)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .stall   (StallD),
    .flush   (ifid_flush),
    .instr   (imem_rdata),
    .pc      (pcf),
    .pc4     (pcf4),
    .instr_q (InstrD),
    .pc_q    (PCD),
    .pc4_q   (PCPlus4D),
    .vld_q   (ValidD)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID words go into a scoreboard
// queue, a negedge monitor pops them whenever decode would consume ValidD.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, start, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
  logic        ValidD, halted;

  logic        w_rst, w_start, zero;
  logic [31:0] zero32, w_addr, w_rdata, w_instr, w_pcd, w_pc4;
  logic        w_vld, w_halted;

  logic [31:0] mem [0:63];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[7:2]];
  assign w_rdata    = ~w_addr;

  fetch_stage dut (
    .clk(clk), .rst(rst), .start(start), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .InstrD(InstrD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .halted(halted)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(w_rst), .start(w_start), .StallF(zero), .StallD(zero),
    .FlushD(zero), .PCSrcE(zero), .PCTargetE(zero32),
    .imem_addr(w_addr), .imem_rdata(w_rdata), .InstrD(w_instr),
    .PCD(w_pcd), .PCPlus4D(w_pc4), .ValidD(w_vld), .halted(w_halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t x;
    x.pc    = pc;
    x.instr = instr;
    sbq.push_back(x);
  endtask

  // Decode consumes IF/ID when it is valid and not stalled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ValidD && !StallD) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got PCD=%h with empty scoreboard", PCD);
        end else begin
          e = sbq.pop_front();
          chk("sb_PCD", PCD, e.pc);
          chk("sb_InstrD", InstrD, e.instr);
          chk("sb_PCPlus4D", PCPlus4D, e.pc + 32'd4);
        end
      end else if (!ValidD) begin
        chk("bubble_InstrD", InstrD, 32'h0000_0013);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
    rst = 1'b1; start = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCTargetE = 32'h0;
    w_rst = 1'b1; w_start = 1'b0; zero = 1'b0; zero32 = 32'h0;

    tick();
    rst = 1'b0;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", ValidD, 0);
    chk("rst_instr", InstrD, 32'h13);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_halted", halted, 0);
    repeat (3) begin
      tick();
      chk("idle_addr", imem_addr, 32'h0);
      chk("idle_valid", ValidD, 0);
    end
    mon_en = 1'b1;

    // start: first valid two edges later, then sequential fetch
    push(32'h0, mem[0]); push(32'h4, mem[1]); push(32'h8, mem[2]); push(32'hC, mem[3]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_addr0", imem_addr, 32'h0);
    chk("run_valid0", ValidD, 0);
    repeat (4) tick();
    chk("addr_10", imem_addr, 32'h10);

    // stall both stages for two cycles
    StallF = 1'b1; StallD = 1'b1;
    repeat (2) begin
      tick();
      chk("stall_addr", imem_addr, 32'h10);
      chk("stall_pcd", PCD, 32'hC);
      chk("stall_valid", ValidD, 1);
    end
    StallF = 1'b0; StallD = 1'b0;
    push(32'h10, mem[4]); push(32'h14, mem[5]);
    tick();
    chk("unstall_pcd", PCD, 32'h10);
    tick();
    chk("addr_18", imem_addr, 32'h18);

    // redirect
    PCSrcE = 1'b1; PCTargetE = 32'h40;
    tick();
    PCSrcE = 1'b0;
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_valid", ValidD, 0);
    push(32'h40, mem[16]);
    tick();

    // redirect beats StallF
    PCSrcE = 1'b1; StallF = 1'b1; PCTargetE = 32'h80;
    tick();
    PCSrcE = 1'b0; StallF = 1'b0;
    chk("redir_stall_addr", imem_addr, 32'h80);
    chk("redir_stall_valid", ValidD, 0);
    push(32'h80, mem[32]);
    tick();
    tick();

    // flush beats StallD; PC still advances
    FlushD = 1'b1; StallD = 1'b1;
    tick();
    FlushD = 1'b0; StallD = 1'b0;
    chk("flush_instr", InstrD, 32'h13);
    chk("flush_valid", ValidD, 0);
    chk("flush_addr", imem_addr, 32'h8C);
    push(32'h8C, mem[35]);
    tick();

    // halt at 0x08
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_addr", imem_addr, 32'h0);
    chk("rst2_valid", ValidD, 0);
    mem[2] = 32'h0000_0073;
    push(32'h0, mem[0]); push(32'h4, mem[1]); push(32'h8, 32'h0000_0073);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("halt_flag", halted, 1);
    chk("halt_addr", imem_addr, 32'h8);
    repeat (3) begin
      tick();
      chk("halted_flag", halted, 1);
      chk("halted_addr", imem_addr, 32'h8);
      chk("halted_valid", ValidD, 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("unhalt_flag", halted, 0);
    chk("unhalt_addr", imem_addr, 32'h0);

    // redirect/flush in IDLE only produce bubbles
    PCSrcE = 1'b1; PCTargetE = 32'h40; FlushD = 1'b1;
    tick();
    PCSrcE = 1'b0; FlushD = 1'b0;
    chk("idle_redir_addr", imem_addr, 32'h0);
    chk("idle_redir_valid", ValidD, 0);
    mon_en = 1'b0;
    chk("sb_empty", sbq.size(), 0);

    // PC wrap and reset mid-run on the second instance
    tick();
    w_rst = 1'b0;
    chk("w_rst_addr", w_addr, 32'hFFFF_FFF8);
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    tick();
    chk("w_pcd0", w_pcd, 32'hFFFF_FFF8);
    chk("w_instr0", w_instr, 32'h0000_0007);
    chk("w_valid0", w_vld, 1);
    tick();
    chk("w_pcd1", w_pcd, 32'hFFFF_FFFC);
    chk("w_pc4_1", w_pc4, 32'h0);
    tick();
    chk("w_pcd2", w_pcd, 32'h0);
    chk("w_pc4_2", w_pc4, 32'h4);
    chk("w_addr2", w_addr, 32'h4);
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    chk("w_mid_addr", w_addr, 32'hFFFF_FFF8);
    chk("w_mid_valid", w_vld, 0);
    chk("w_mid_instr", w_instr, 32'h13);
    chk("w_mid_pcd", w_pcd, 32'h0);
    chk("w_mid_pc4", w_pc4, 32'h0);
    chk("w_mid_halted", w_halted, 0);
    tick();
    chk("w_idle_addr", w_addr, 32'hFFFF_FFF8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
